// File: rtl/pwm_capture.sv
// PWM period / high-time capture: measures an asynchronous PWM input in clk cycles,
// reporting each complete period with a one-cycle valid, and flagging a lost signal.
module pwm_capture #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period_cnt,
  output logic [CNT_W-1:0] high_cnt,
  output logic             valid,
  output logic             timeout,
  output logic             stuck_level
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // Last value a counter may hold; the next increment would saturate it.
  localparam logic [CNT_W-1:0] CNT_LAST = {CNT_W{1'b1}} - CNT_ONE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             sync1_q, sync1_d;
  logic             pwm_s_q, pwm_s_d;
  logic             pwm_d_q, pwm_d_d;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] hi_q, hi_d;
  logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic             stuck_level_q, stuck_level_d;

  assign period_cnt  = period_cnt_q;
  assign high_cnt    = high_cnt_q;
  assign valid       = valid_q;
  assign timeout     = timeout_q;
  assign stuck_level = stuck_level_q;

  // Next-state: synchronizer, registered edge detect, measurement FSM and result registers.
  // pwm_d_q is the level aligned with rise_q, so the FSM counts phases on that copy.
  always_comb begin
    sync1_d       = pwm_in;
    pwm_s_d       = sync1_q;
    pwm_d_d       = pwm_s_q;
    rise_d        = pwm_s_q & ~pwm_d_q;
    state_d       = state_q;
    per_d         = per_q;
    hi_d          = hi_q;
    period_cnt_d  = period_cnt_q;
    high_cnt_d    = high_cnt_q;
    valid_d       = 1'b0;
    timeout_d     = timeout_q;
    stuck_level_d = stuck_level_q;

    if (!en) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rise_q) begin
            state_d = HIGH;
            per_d   = CNT_ONE;
            hi_d    = CNT_ONE;
          end
        end
        HIGH: begin
          if (per_q == CNT_LAST) begin
            state_d       = IDLE;
            timeout_d     = 1'b1;
            stuck_level_d = pwm_s_q;
          end else if (pwm_d_q) begin
            per_d = per_q + CNT_ONE;
            hi_d  = hi_q + CNT_ONE;
          end else begin
            per_d   = per_q + CNT_ONE;
            state_d = LOW;
          end
        end
        LOW: begin
          if (rise_q) begin
            period_cnt_d = per_q;
            high_cnt_d   = hi_q;
            valid_d      = 1'b1;
            timeout_d    = 1'b0;
            per_d        = CNT_ONE;
            hi_d         = CNT_ONE;
            state_d      = HIGH;
          end else if (per_q == CNT_LAST) begin
            state_d       = IDLE;
            timeout_d     = 1'b1;
            stuck_level_d = pwm_s_q;
          end else begin
            per_d = per_q + CNT_ONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      sync1_q       <= 1'b0;
      pwm_s_q       <= 1'b0;
      pwm_d_q       <= 1'b0;
      rise_q        <= 1'b0;
      per_q         <= '0;
      hi_q          <= '0;
      period_cnt_q  <= '0;
      high_cnt_q    <= '0;
      valid_q       <= 1'b0;
      timeout_q     <= 1'b0;
      stuck_level_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync1_q       <= sync1_d;
      pwm_s_q       <= pwm_s_d;
      pwm_d_q       <= pwm_d_d;
      rise_q        <= rise_d;
      per_q         <= per_d;
      hi_q          <= hi_d;
      period_cnt_q  <= period_cnt_d;
      high_cnt_q    <= high_cnt_d;
      valid_q       <= valid_d;
      timeout_q     <= timeout_d;
      stuck_level_q <= stuck_level_d;
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: waveforms are built from (high, low) segment lists and the
// expected results come straight from those lengths and the drive cycle of each rise.
module tb_pwm_capture;

  localparam int unsigned W4 = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        pwm_in;
  logic [15:0] period16, high16;
  logic        valid16, timeout16, stuck16;
  logic [3:0]  period4, high4;
  logic        valid4, timeout4, stuck4;

  always #5 clk = ~clk;

  pwm_capture #(.CNT_W(16)) dut16 (
    .clk(clk), .rst(rst), .en(en), .pwm_in(pwm_in),
    .period_cnt(period16), .high_cnt(high16), .valid(valid16),
    .timeout(timeout16), .stuck_level(stuck16)
  );

  pwm_capture #(.CNT_W(W4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .pwm_in(pwm_in),
    .period_cnt(period4), .high_cnt(high4), .valid(valid4),
    .timeout(timeout4), .stuck_level(stuck4)
  );

  typedef struct {
    int cyc;
    int per;
    int hi;
  } ev_t;

  ev_t q16[$];
  ev_t q4[$];
  int  cyc = 0;
  int  to4_cyc = -1;
  logic to4_prev = 1'b0;
  int  n_checks = 0;
  int  n_pass = 0;
  int  rise_cyc = 0;
  int  sh[$];
  int  sl[$];
  int  rc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Record every valid pulse and the first cycle of each dut4 timeout assertion.
  always @(negedge clk) begin
    ev_t e;
    if (valid16) begin
      e.cyc = cyc; e.per = int'(period16); e.hi = int'(high16);
      q16.push_back(e);
    end
    if (valid4) begin
      e.cyc = cyc; e.per = int'(period4); e.hi = int'(high4);
      q4.push_back(e);
    end
    if (timeout4 && !to4_prev) to4_cyc = cyc;
    to4_prev = timeout4;
  end

  // Drive pwm_in to v for n clock cycles; remember the cycle of a 0->1 change.
  task automatic drive_level(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (v && !pwm_in) rise_cyc = cyc;
      pwm_in = v;
    end
  endtask

  // Bring both DUTs back to IDLE with the input low.
  task automatic settle();
    @(negedge clk);
    en = 1'b0;
    pwm_in = 1'b0;
    repeat (6) @(negedge clk);
    en = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Play the segment lists, then one closing rise so every segment gets reported.
  task automatic play();
    rc.delete();
    foreach (sh[k]) begin
      drive_level(1'b1, sh[k]);
      rc.push_back(rise_cyc);
      drive_level(1'b0, sl[k]);
    end
    drive_level(1'b1, 1);
    rc.push_back(rise_cyc);
    drive_level(1'b0, 6);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (period16 !== 16'd0) $display("FAIL reset_period got %0d want 0", period16); else n_pass++;
    n_checks++; if (high16 !== 16'd0) $display("FAIL reset_high got %0d want 0", high16); else n_pass++;
    n_checks++; if (valid16 !== 1'b0) $display("FAIL reset_valid got %b want 0", valid16); else n_pass++;
    n_checks++; if (timeout16 !== 1'b0) $display("FAIL reset_timeout got %b want 0", timeout16); else n_pass++;
    n_checks++; if (stuck16 !== 1'b0) $display("FAIL reset_stuck got %b want 0", stuck16); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Play sh/sl from IDLE and compare each reported period against the segment lengths.
  task automatic test_pattern(input string name);
    int base;
    ev_t e;
    settle();
    base = q16.size();
    play();
    @(negedge clk);
    #1;
    n_checks++;
    if (q16.size() - base !== sh.size())
      $display("FAIL %s_count got %0d want %0d", name, q16.size() - base, sh.size());
    else n_pass++;
    foreach (sh[k]) begin
      if (base + k < q16.size()) begin
        e = q16[base + k];
        n_checks++;
        if (e.per !== sh[k] + sl[k]) $display("FAIL %s_period[%0d] got %0d want %0d", name, k, e.per, sh[k] + sl[k]);
        else n_pass++;
        n_checks++;
        if (e.hi !== sh[k]) $display("FAIL %s_high[%0d] got %0d want %0d", name, k, e.hi, sh[k]);
        else n_pass++;
        n_checks++;
        if (e.cyc !== rc[k + 1] + 4) $display("FAIL %s_latency[%0d] got cycle %0d want %0d", name, k, e.cyc, rc[k + 1] + 4);
        else n_pass++;
      end
    end
  endtask

  task automatic test_steady();
    sh.delete(); sl.delete();
    repeat (6) begin sh.push_back(3); sl.push_back(5); end
    test_pattern("steady");
  endtask

  task automatic test_extremes();
    sh.delete(); sl.delete();
    repeat (3) begin sh.push_back(1); sl.push_back(1); end
    test_pattern("min");
    sh.delete(); sl.delete();
    repeat (2) begin sh.push_back(200); sl.push_back(56); end
    test_pattern("wide");
  endtask

  task automatic test_random();
    sh.delete(); sl.delete();
    repeat (12) begin
      sh.push_back(int'($urandom_range(1, 24)));
      sl.push_back(int'($urandom_range(1, 24)));
    end
    test_pattern("random");
  endtask

  task automatic test_enable();
    int base;
    settle();
    base = q16.size();
    drive_level(1'b1, 4); drive_level(1'b0, 6);
    drive_level(1'b1, 4); drive_level(1'b0, 6);
    drive_level(1'b1, 2); drive_level(1'b0, 3);
    @(negedge clk);
    en = 1'b0;
    repeat (3) begin drive_level(1'b1, 3); drive_level(1'b0, 3); end
    #1;
    n_checks++;
    if (q16.size() - base !== 2) $display("FAIL en_off_count got %0d want 2", q16.size() - base); else n_pass++;
    n_checks++; if (period16 !== 16'd10) $display("FAIL en_hold_period got %0d want 10", period16); else n_pass++;
    n_checks++; if (high16 !== 16'd4) $display("FAIL en_hold_high got %0d want 4", high16); else n_pass++;
    drive_level(1'b0, 2);
    en = 1'b1;
    drive_level(1'b0, 4);
    repeat (2) begin drive_level(1'b1, 7); drive_level(1'b0, 2); end
    drive_level(1'b1, 1); drive_level(1'b0, 6);
    #1;
    n_checks++;
    if (q16.size() - base !== 4) $display("FAIL en_on_count got %0d want 4", q16.size() - base); else n_pass++;
    if (q16.size() - base >= 3) begin
      n_checks++;
      if (q16[base + 2].per !== 9 || q16[base + 2].hi !== 7)
        $display("FAIL en_first_result got %0d/%0d want 9/7", q16[base + 2].per, q16[base + 2].hi);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int base;
    settle();
    base = q16.size();
    drive_level(1'b1, 6); drive_level(1'b0, 4);
    drive_level(1'b1, 6);
    #1;
    n_checks++; if (period16 !== 16'd10) $display("FAIL pre_rst_period got %0d want 10", period16); else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    pwm_in = 1'b0;
    #1;
    n_checks++;
    if (period16 !== 16'd0 || high16 !== 16'd0 || valid16 !== 1'b0 || timeout16 !== 1'b0 || stuck16 !== 1'b0)
      $display("FAIL rst_async got %0d/%0d/%b/%b/%b want 0/0/0/0/0", period16, high16, valid16, timeout16, stuck16);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    base = q16.size();
    drive_level(1'b0, 4);
    repeat (2) begin drive_level(1'b1, 5); drive_level(1'b0, 3); end
    drive_level(1'b1, 1); drive_level(1'b0, 6);
    #1;
    n_checks++;
    if (q16.size() - base !== 2) $display("FAIL post_rst_count got %0d want 2", q16.size() - base); else n_pass++;
    if (q16.size() > base) begin
      n_checks++;
      if (q16[base].per !== 8 || q16[base].hi !== 5)
        $display("FAIL post_rst_result got %0d/%0d want 8/5", q16[base].per, q16[base].hi);
      else n_pass++;
    end
  endtask

  task automatic test_timeout();
    int base;
    int exp_to;
    int r0;
    @(negedge clk);
    rst = 1'b1; pwm_in = 1'b0; en = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (timeout4 !== 1'b0) $display("FAIL to_initial got %b want 0", timeout4); else n_pass++;
    base = q4.size();
    drive_level(1'b0, 3);
    drive_level(1'b1, 30);
    r0 = rise_cyc;
    exp_to = r0 + 4 + ((1 << W4) - 1) - 1;
    #1;
    n_checks++; if (to4_cyc !== exp_to) $display("FAIL to_cycle got %0d want %0d", to4_cyc, exp_to); else n_pass++;
    n_checks++; if (timeout4 !== 1'b1) $display("FAIL to_high_flag got %b want 1", timeout4); else n_pass++;
    n_checks++; if (stuck4 !== 1'b1) $display("FAIL to_high_stuck got %b want 1", stuck4); else n_pass++;
    n_checks++; if (q4.size() !== base) $display("FAIL to_no_valid got %0d want %0d", q4.size(), base); else n_pass++;
    drive_level(1'b0, 4);
    repeat (3) begin drive_level(1'b1, 4); drive_level(1'b0, 4); end
    drive_level(1'b1, 1); drive_level(1'b0, 6);
    #1;
    n_checks++;
    if (q4.size() - base !== 3) $display("FAIL to_recover_count got %0d want 3", q4.size() - base); else n_pass++;
    if (q4.size() > base) begin
      n_checks++;
      if (q4[base].per !== 8 || q4[base].hi !== 4)
        $display("FAIL to_recover_result got %0d/%0d want 8/4", q4[base].per, q4[base].hi);
      else n_pass++;
    end
    n_checks++; if (timeout4 !== 1'b0) $display("FAIL to_cleared got %b want 0", timeout4); else n_pass++;
    drive_level(1'b0, 30);
    #1;
    n_checks++; if (timeout4 !== 1'b1) $display("FAIL to_low_flag got %b want 1", timeout4); else n_pass++;
    n_checks++; if (stuck4 !== 1'b0) $display("FAIL to_low_stuck got %b want 0", stuck4); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_steady();
    test_extremes();
    test_random();
    test_enable();
    test_reset_mid();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
